// File: rtl/sccb_ov5640_slave.sv
// rtl/sccb_ov5640_slave.sv - SCCB register slave with 16-bit auto-incrementing pointer
// Read path is built only when SCCB_SLAVE_READ_EN is defined.
module sccb_ov5640_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {IDLE, DEV, ADDR_H, ADDR_L, DATA, RD, ACK, WAIT_STOP} state_t;

    // Bus sampling vectors: bit 0 is SCL, bit 1 is SDA.
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d, prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_t      state_q, state_d, nxt_q, nxt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, addr_h_q, addr_h_d;
    logic [15:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        sda_oe_q, sda_oe_d, wr_valid_q, wr_valid_d, busy_q, busy_d;
`ifdef SCCB_SLAVE_READ_EN
    logic [7:0]  rd_shift_q, rd_shift_d;
    logic        mack_q, mack_d, mack_ok_q, mack_ok_d;
`else
    logic        unused_rd_data;
    assign unused_rd_data = ^rd_data;
`endif

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    assign sync1_d   = {sda_i, scl_i};
    assign sync2_d   = sync1_q;
    assign prev_d    = filt_q;
    assign scl       = filt_q[0];
    assign sda       = filt_q[1];
    assign scl_rise  = scl & ~prev_q[0];
    assign scl_fall  = ~scl & prev_q[0];
    assign start_det = scl & prev_q[0] & prev_q[1] & ~sda;
    assign stop_det  = scl & prev_q[0] & ~prev_q[1] & sda;

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
                else                                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        nxt_d      = nxt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_h_d   = addr_h_q;
        ptr_d      = ptr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        busy_d     = busy_q;
`ifdef SCCB_SLAVE_READ_EN
        rd_shift_d = rd_shift_q;
        mack_d     = mack_q;
        mack_ok_d  = mack_ok_q;
`endif
        if (start_det) begin
            state_d   = DEV;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
`ifdef SCCB_SLAVE_READ_EN
            mack_d    = 1'b0;
`endif
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                DEV, ADDR_H, ADDR_L, DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        state_d   = ACK;
                        sda_oe_d  = 1'b1;
                        case (state_q)
                            DEV: begin
                                if (shift_q[7:1] != DEV_ADDR) begin
                                    state_d  = WAIT_STOP;
                                    sda_oe_d = 1'b0;
                                end else if (!shift_q[0]) begin
                                    nxt_d = ADDR_H;
                                end else begin
`ifdef SCCB_SLAVE_READ_EN
                                    nxt_d = RD;
`else
                                    state_d  = WAIT_STOP;
                                    sda_oe_d = 1'b0;
`endif
                                end
                            end
                            ADDR_H: begin
                                addr_h_d = shift_q;
                                nxt_d    = ADDR_L;
                            end
                            ADDR_L: begin
                                ptr_d = {addr_h_q, shift_q};
                                nxt_d = DATA;
                            end
                            default: begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = shift_q;
                                ptr_d      = ptr_q + 16'd1;
                                nxt_d      = DATA;
                            end
                        endcase
                    end
                end
                ACK: begin
`ifdef SCCB_SLAVE_READ_EN
                    if (mack_q && scl_rise) mack_ok_d = ~sda;
`endif
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        state_d   = nxt_q;
`ifdef SCCB_SLAVE_READ_EN
                        // First read bit goes out on the same falling edge that closes the ACK slot.
                        if (nxt_q == RD) begin
                            rd_shift_d = rd_data;
                            sda_oe_d   = ~rd_data[7];
                        end
                        if (mack_q) begin
                            mack_d = 1'b0;
                            if (!mack_ok_q) begin
                                state_d  = WAIT_STOP;
                                sda_oe_d = 1'b0;
                            end
                        end
`endif
                    end
                end
`ifdef SCCB_SLAVE_READ_EN
                RD: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = ACK;
                            nxt_d     = RD;
                            mack_d    = 1'b1;
                            mack_ok_d = 1'b0;
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + 16'd1;
                            bit_cnt_d = '0;
                        end else begin
                            rd_shift_d = {rd_shift_q[6:0], 1'b0};
                            sda_oe_d   = ~rd_shift_q[6];
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            prev_q     <= 2'b11;
            cnt_q      <= '{default: '0};
            state_q    <= IDLE;
            nxt_q      <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            addr_h_q   <= '0;
            ptr_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
            rd_shift_q <= '0;
            mack_q     <= 1'b0;
            mack_ok_q  <= 1'b0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            nxt_q      <= nxt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_h_q   <= addr_h_d;
            ptr_q      <= ptr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            busy_q     <= busy_d;
`ifdef SCCB_SLAVE_READ_EN
            rd_shift_q <= rd_shift_d;
            mack_q     <= mack_d;
            mack_ok_q  <= mack_ok_d;
`endif
        end
    end

    assign sda_oe   = sda_oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_addr  = ptr_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_sccb_ov5640_slave.sv
// tb/tb_sccb_ov5640_slave.sv - randomized scoreboard bench for sccb_ov5640_slave
module tb_sccb_ov5640_slave;
    localparam int Q = 100;
`ifdef SCCB_SLAVE_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic scl_m = 1'b1, sda_m = 1'b1, scl_glitch = 1'b0;
    logic scl_i, sda_i, sda_oe, wr_valid, busy;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    assign scl_i   = scl_m & ~scl_glitch;
    assign sda_i   = sda_m & ~sda_oe;
    assign rd_data = (rd_addr == 16'h300A) ? 8'h56 : 8'hC3;

    sccb_ov5640_slave dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] a; logic [7:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    logic [7:0] txq[$];
    logic [15:0] m_ptr = 16'h0000;
    int total = 0, bad = 0;
    int quiet_hits = 0, hold_viol = 0, oe_viol = 0;
    logic quiet = 1'b0;
    logic [15:0] last_addr = 16'h0;
    logic [7:0] last_data = 8'h0;
    logic last_oe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected actual=%h/%h required=none", wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", {16'h0, wr_addr}, {16'h0, mon_e.a});
                    check("wr_data", {24'h0, wr_data}, {24'h0, mon_e.d});
                end
            end else if (wr_addr != last_addr || wr_data != last_data) begin
                hold_viol++;
            end
            if (sda_oe != last_oe && scl_m) oe_viol++;
            if (quiet && sda_oe) quiet_hits++;
        end
        last_addr = wr_addr;
        last_data = wr_data;
        last_oe   = sda_oe;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_start();
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic bus_bit(input logic b, input bit glitch, output logic s);
        sda_m = b; #Q;
        scl_m = 1'b1; #Q;
        if (glitch) begin
            @(posedge clk); #1 scl_glitch = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1 scl_glitch = 1'b0;
        end
        s = sda_i; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_byte(input logic [7:0] b, input int nbits, input int gpos, output logic ack);
        logic s;
        for (int i = 0; i < nbits; i++) bus_bit(b[7-i], i == gpos, s);
        ack = 1'b0;
        if (nbits == 8) begin
            bus_bit(1'b1, 1'b0, s);
            ack = ~s;
        end
    endtask

    task automatic bus_read(input logic master_ack, output logic [7:0] v);
        logic s;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, 1'b0, s);
            v = {v[6:0], s};
        end
        bus_bit(~master_ack, 1'b0, s);
    endtask

    // Reference model: device 0x3C write frames carry a 16-bit pointer then data bytes
    // written to consecutive addresses; anything else is ignored until STOP.
    task automatic run_write(input string tag, input bit do_stop, input int gbyte, input int gbit);
        logic ack, exp_ack, live;
        bus_start();
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        live = (txq[0] == 8'h78);
        for (int i = 0; i < txq.size(); i++) begin
            if (i == 0) exp_ack = (txq[0][7:1] == 7'h3C) && (!txq[0][0] || READ_EN);
            else        exp_ack = live;
            if (live && i == 2) m_ptr = {txq[1], txq[2]};
            if (live && i >= 3) begin
                exp_q.push_back('{a: m_ptr, d: txq[i]});
                m_ptr = m_ptr + 16'd1;
            end
            bus_byte(txq[i], 8, (i == gbyte) ? gbit : -1, ack);
            check($sformatf("%s_ack%0d", tag, i), {31'h0, ack}, {31'h0, exp_ack});
        end
        if (do_stop) begin
            bus_stop();
            #(2*Q);
            check({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
            check({tag, "_rd_addr"}, {16'h0, rd_addr}, {16'h0, m_ptr});
        end
    endtask

    initial begin
        logic ack;
        logic [7:0] b, v;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
        check("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        check("rst_wr_addr", {16'h0, wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, wr_data}, 32'h0);
        check("rst_rd_addr", {16'h0, rd_addr}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        #(2*Q);

        txq = '{8'h78, 8'h31, 8'h03, 8'h11};
        run_write("basic", 1'b1, -1, -1);

        quiet = 1'b1;
        txq = '{8'h42, 8'h30};
        run_write("nack", 1'b1, -1, -1);
        quiet = 1'b0;
        check("nack_sda_quiet", quiet_hits, 0);

        txq = '{8'h78, 8'hFF, 8'hFF, 8'hAA, 8'hBB, 8'hCC};
        run_write("wrap", 1'b1, -1, -1);

        for (int t = 0; t < 6; t++) begin
            b = 8'h78;
            if ($urandom_range(0, 3) == 0) begin
                do b = 8'($urandom_range(0, 255)); while (b[7:1] == 7'h3C);
            end
            txq = '{b, 8'($urandom), 8'($urandom)};
            for (int k = $urandom_range(0, 3); k > 0; k--) txq.push_back(8'($urandom));
            run_write($sformatf("rnd%0d", t), 1'b1, -1, -1);
        end

        bus_start();
        bus_byte(8'h78, 8, -1, ack);
        bus_byte(8'h12, 8, -1, ack);
        bus_byte(8'h34, 8, -1, ack);
        m_ptr = 16'h1234;
        bus_byte(8'h5A, 5, -1, ack);
        bus_stop();
        #(2*Q);
        check("abort_sda_oe", {31'h0, sda_oe}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_rd_addr", {16'h0, rd_addr}, {16'h0, m_ptr});

        bus_start();
        bus_byte(8'h78, 8, -1, ack);
        bus_byte(8'h56, 8, -1, ack);
        bus_byte(8'h9E, 4, -1, ack);
        rst_n = 1'b0;
        #1;
        m_ptr = 16'h0000;
        check("rstx_sda_oe", {31'h0, sda_oe}, 32'h0);
        check("rstx_busy", {31'h0, busy}, 32'h0);
        check("rstx_rd_addr", {16'h0, rd_addr}, 32'h0);
        check("rstx_wr_addr", {16'h0, wr_addr}, 32'h0);
        sda_m = 1'b1;
        #Q;
        rst_n = 1'b1;
        #Q;
        scl_m = 1'b1;
        #(4*Q);
        check("rstx_idle_busy", {31'h0, busy}, 32'h0);
        check("rstx_idle_oe", {31'h0, sda_oe}, 32'h0);

        txq = '{8'h78, 8'h20, 8'h40, 8'h9C};
        run_write("glitch", 1'b1, 3, 3);

        txq = '{8'h78, 8'h30, 8'h0A};
        run_write("ptr", 1'b0, -1, -1);
        bus_start();
        bus_byte(8'h79, 8, -1, ack);
        check("rd_dev_ack", {31'h0, ack}, {31'h0, READ_EN});
        if (READ_EN) begin
            bus_read(1'b0, v);
            check("rd_byte", {24'h0, v}, 32'h56);
            m_ptr = 16'h300B;
        end else begin
            bus_byte(8'h55, 8, -1, ack);
            check("rd_ignored_ack", {31'h0, ack}, 32'h0);
        end
        bus_stop();
        #(2*Q);
        check("rd_rd_addr", {16'h0, rd_addr}, {16'h0, m_ptr});
        check("rd_busy_end", {31'h0, busy}, 32'h0);

        if (READ_EN) begin
            txq = '{8'h78, 8'h30, 8'h0A};
            run_write("ptr2", 1'b0, -1, -1);
            bus_start();
            bus_byte(8'h79, 8, -1, ack);
            bus_read(1'b1, v);
            check("rd2_byte0", {24'h0, v}, 32'h56);
            bus_read(1'b0, v);
            check("rd2_byte1", {24'h0, v}, 32'hC3);
            bus_stop();
            #(2*Q);
            check("rd2_rd_addr", {16'h0, rd_addr}, 32'h300C);
        end

        #(4*Q);
        check("sb_empty", exp_q.size(), 0);
        check("wr_hold_stable", hold_viol, 0);
        check("sda_oe_scl_high", oe_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sccb_ov5640_slave.md
SCCB_OV5640_SLAVE -- requirements
Module: sccb_ov5640_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C, meaning the 7-bit SCCB device address (0x78 write / 0x79 read on the wire).
REQ-002 SHALL have parameter FILTER_LEN, default 3, meaning the number of consecutive equal clk samples required to accept a new SCL/SDA level.
REQ-003 SHALL have port clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port scl_i  input  1  SCCB clock from the bus, asynchronous to clk.
REQ-006 SHALL have port sda_i  input  1  SCCB data from the bus, asynchronous to clk.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low (ACK or read data 0); 0 = release SDA.
REQ-008 SHALL have port wr_valid  output  1  one-clk pulse marking a completed register write.
REQ-009 SHALL have port wr_addr  output  16  register address of the current write.
REQ-010 SHALL have port wr_data  output  8  register data of the current write.
REQ-011 SHALL have port rd_addr  output  16  current register pointer, for the read path.
REQ-012 SHALL have port rd_data  input  8  register contents at rd_addr, sampled combinationally.
REQ-013 SHALL have port busy  output  1  high from an accepted START until STOP or abort.

Function
- REQ-014 SHALL pass scl_i and sda_i through a 2-flop synchronizer, then a FILTER_LEN-sample glitch filter; all later logic uses only the filtered levels.
- REQ-015 SHALL detect START (SDA falls while SCL high) and STOP (SDA rises while SCL high); a START seen mid-transfer SHALL be a repeated START that re-enters DEV.
- REQ-016 States: IDLE, DEV, ADDR_H, ADDR_L, DATA, RD, ACK, WAIT_STOP.
- REQ-017 Bits SHALL be sampled MSB first on the filtered SCL rising edge; the 9th clock of each byte is the ACK slot.
- REQ-018 DEV: if the address matches DEV_ADDR, the slave SHALL ACK by asserting sda_oe from the SCL falling edge after bit 8 until the next SCL falling edge; on mismatch it SHALL not ACK and SHALL go to WAIT_STOP.
- REQ-019 For a write: ADDR_H then ADDR_L SHALL each be ACKed, and the 16-bit pointer is loaded after ADDR_L.
- REQ-020 For each DATA byte, wr_valid SHALL pulse for one clk, in the cycle after the SCL falling edge that ends bit 8, together with sda_oe rising.
- REQ-021 wr_addr and wr_data SHALL be held stable from that pulse until the next pulse.
- REQ-022 After each DATA byte the pointer SHALL increment by 1, wrapping 16'hFFFF to 16'h0000.
- REQ-023 A STOP or START arriving before bit 8 of any byte SHALL abort that byte with no wr_valid and no pointer change.
- REQ-024 In WAIT_STOP the slave SHALL ignore all traffic until STOP (to IDLE) or START (to DEV).
- REQ-025 sda_oe SHALL never change while filtered SCL is high, except when it is forced to 0 by STOP or abort.

Reset
- REQ-026 Asserting rst_n low SHALL immediately force: state IDLE, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0; synchronizer and filter flops SHALL reset to 1 (idle bus).
- REQ-027 A reset during a transfer SHALL release SDA at once; after reset release, the slave SHALL stay in IDLE until a new START.

Configuration
- REQ-028 Macro SCCB_SLAVE_READ_EN.
- REQ-029 With SCCB_SLAVE_READ_EN defined: a matching address with R/W=1 SHALL be ACKed and enter RD.
  - RD SHALL drive rd_data MSB first, with sda_oe = ~bit, changing only on SCL falling edges.
  - After each byte the pointer SHALL increment, and RD SHALL continue while the master ACKs.
  - A master NACK SHALL go to WAIT_STOP.
- REQ-030 Without SCCB_SLAVE_READ_EN: R/W=1 SHALL be NACKed and go to WAIT_STOP, no RD logic SHALL be synthesized, and rd_data SHALL be unused.

Verification
- REQ-031 START, 0x78, 0x31, 0x03, 0x11, STOP -> four ACKs, one wr_valid with wr_addr=16'h3103 and wr_data=8'h11, busy low after STOP.
- REQ-032 START, 0x42, 0x30, STOP -> no ACK on any byte, no wr_valid, sda_oe=0 throughout.
- REQ-033 START, 0x78, 0xFF, 0xFF, 0xAA, 0xBB, 0xCC, STOP -> three wr_valid pulses at addresses FFFF, 0000, 0001 with data AA, BB, CC.
- REQ-034 STOP after bit 5 of the data byte, and separately rst_n low during ADDR_L -> no wr_valid, sda_oe=0, state IDLE.
- REQ-035 SCL glitch of FILTER_LEN-1 clk cycles in the middle of a data bit -> no extra bit sampled, and the write completes correctly.
- REQ-036 With SCCB_SLAVE_READ_EN: write pointer 0x300A, then repeated START, 0x79, with rd_data=8'h56, then master NACK -> SDA carries 0x56 and rd_addr ends at 16'h300B; without the macro -> 0x79 NACKed.
